lcd_hd44780_ctrl: RTL



---
 rtl/lcd_hd44780_ctrl_pkg.sv | 46 ++++
 rtl/lcd_hd44780_ctrl_timer.sv | 37 +++
 rtl/lcd_hd44780_ctrl.sv | 304 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/lcd_hd44780_ctrl_pkg.sv
// Shared definitions for the HD44780 character-LCD write sequencer:
// FSM state encoding, the power-up init ROM and the clear/home detector.
// Used by lcd_hd44780_ctrl and lcd_timer. Optional macro LCD_BUSY_POLL_EN
// (consumed by the top) enables the busy-flag poll states listed here.
package lcd_pkg;

    // Poll states are always encoded so the enum stays identical in both builds
    typedef enum logic [3:0] {
        ST_PWRUP,
        ST_LOAD,
        ST_SETUP,
        ST_EN,
        ST_HOLD,
        ST_DELAY,
        ST_IDLE,
        ST_POLL_SU,
        ST_POLL_EN,
        ST_POLL_HOLD
    } lcd_state_e;

    localparam int INIT_LEN = 6;

    // Index of the final init entry and first entry allowed to busy-poll
    localparam logic [2:0] INIT_LAST_IDX  = 3'(INIT_LEN - 1);
    localparam logic [2:0] POLL_FIRST_IDX = 3'd3;

    // Init ROM, {rs, data}; entry 0 is the rightmost element
    localparam logic [INIT_LEN-1:0][8:0] INIT_ROM = {
        9'h006, // entry mode: increment, no shift
        9'h001, // clear display
        9'h00C, // display on, cursor off
        9'h038, // function set 8-bit, 2 lines
        9'h038,
        9'h038
    };

    // Clear (0x01) and return-home (0x02/0x03) need the long execution delay
    function automatic logic is_long_cmd(input logic [8:0] wr);
        return (wr[8] == 1'b0) && (wr[7:2] == 6'd0) && (wr[1:0] != 2'd0);
    endfunction

    function automatic int max_of(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/lcd_hd44780_ctrl_timer.sv
// lcd_timer: loadable down-counter shared by every timed FSM state.
// A load of N makes done assert N cycles later (N=0 behaves as N=1);
// the counter then parks at zero until the next load.
module lcd_timer
    import lcd_pkg::*;
#(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic [W-1:0] value,
    output logic         done
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    // Next count: reload, otherwise decrement until zero
    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = (load_val == '0) ? '0 : (load_val - W'(1));
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - W'(1);
        end
    end

    // Count register; the owner forces a load while in reset
    always_ff @(posedge clk) begin
        cnt_q <= cnt_d;
    end

    assign value = cnt_q;
    assign done  = (cnt_q == '0);

endmodule

// File: rtl/lcd_hd44780_ctrl.sv
// lcd_hd44780_ctrl: HD44780 write sequencer. Runs the power-up init
// sequence after reset, then accepts {rs, byte} over valid/ready and
// generates setup / enable / hold timing plus the command execution delay.
// Optional macro LCD_BUSY_POLL_EN replaces the fixed post-write delay with a
// busy-flag read loop (bounded by T_LONG_CYC) for user writes and init 3..5.
module lcd_hd44780_ctrl
    import lcd_pkg::*;
#(
    parameter int T_PWRUP_CYC = 750000,
    parameter int T_SU_CYC    = 2,
    parameter int T_EN_CYC    = 12,
    parameter int T_HOLD_CYC  = 2,
    parameter int T_CMD_CYC   = 2000,
    parameter int T_LONG_CYC  = 82000
) (
    input  logic       clk_clk,
    input  logic       reset_reset_n,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic       in_rs,
    input  logic [7:0] in_data,
    output logic       init_done,
    output logic       busy,
    output logic [7:0] lcd_data_o,
    input  logic [7:0] lcd_data_i,
    output logic       lcd_data_oe,
    output logic       lcd_en,
    output logic       lcd_rs,
    output logic       lcd_rw
);

    localparam int T_MAX = max_of(max_of(max_of(T_PWRUP_CYC, T_SU_CYC), max_of(T_EN_CYC, T_HOLD_CYC)),
                                  max_of(T_CMD_CYC, T_LONG_CYC));
    localparam int TW = $clog2(T_MAX) + 1;

    localparam logic [TW-1:0] LD_PWRUP = TW'(T_PWRUP_CYC);
    localparam logic [TW-1:0] LD_SU    = TW'(T_SU_CYC);
    localparam logic [TW-1:0] LD_EN    = TW'(T_EN_CYC);
    localparam logic [TW-1:0] LD_HOLD  = TW'(T_HOLD_CYC);
    localparam logic [TW-1:0] LD_CMD   = TW'(T_CMD_CYC);
    localparam logic [TW-1:0] LD_LONG  = TW'(T_LONG_CYC);

    lcd_state_e state_q, state_d;
    logic [2:0] init_idx_q, init_idx_d;
    logic       init_done_q, init_done_d;
    logic [8:0] wr_q, wr_d;

    logic          tmr_load;
    logic [TW-1:0] tmr_val;
    logic [TW-1:0] tmr_value_unused;
    logic          tmr_done;

    logic finish;
    logic adv_init;

    logic       lcd_en_q, lcd_en_d;
    logic       lcd_rs_q, lcd_rs_d;
    logic [7:0] lcd_data_q, lcd_data_d;
    logic       in_ready_q, in_ready_d;
    logic       busy_q, busy_d;

`ifdef LCD_BUSY_POLL_EN
    logic          lcd_rw_q, lcd_rw_d;
    logic          lcd_oe_q, lcd_oe_d;
    logic [TW-1:0] poll_cnt_q, poll_cnt_d;
    logic          poll_busy_q, poll_busy_d;
    logic          use_poll;
    logic          poll_timeout;
    logic          poll_phase;

    // Init entries 0..2 precede a valid busy flag, so they keep fixed delays
    assign use_poll     = init_done_q || (init_idx_q >= POLL_FIRST_IDX);
    assign poll_timeout = (poll_cnt_q == (LD_LONG - TW'(1)));
`else
    logic lcd_data_i_unused;
    assign lcd_data_i_unused = ^lcd_data_i;
`endif

    // More init entries remain after the one just written
    assign adv_init = !init_done_q && (init_idx_q < INIT_LAST_IDX);

    lcd_timer #(
        .W(TW)
    ) u_timer (
        .clk      (clk_clk),
        .load     (tmr_load),
        .load_val (tmr_val),
        .value    (tmr_value_unused),
        .done     (tmr_done)
    );

    // Control state register with synchronous active-low reset
    always_ff @(posedge clk_clk) begin
        if (!reset_reset_n) begin
            state_q     <= ST_PWRUP;
            init_idx_q  <= 3'd0;
            init_done_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            init_idx_q  <= init_idx_d;
            init_done_q <= init_done_d;
        end
    end

    // Datapath registers: byte in flight and poll bookkeeping
    always_ff @(posedge clk_clk) begin
        wr_q <= wr_d;
`ifdef LCD_BUSY_POLL_EN
        poll_cnt_q  <= poll_cnt_d;
        poll_busy_q <= poll_busy_d;
`endif
    end

    // Next-state logic, timer loads and init sequencing
    always_comb begin
        state_d     = state_q;
        init_idx_d  = init_idx_q;
        init_done_d = init_done_q;
        wr_d        = wr_q;
        tmr_load    = 1'b0;
        tmr_val     = LD_PWRUP;
        finish      = 1'b0;
`ifdef LCD_BUSY_POLL_EN
        poll_cnt_d  = poll_cnt_q;
        poll_busy_d = poll_busy_q;
`endif
        case (state_q)
            ST_PWRUP: begin
                if (tmr_done) begin
                    state_d = ST_LOAD;
                    wr_d    = INIT_ROM[init_idx_q];
                end
            end
            ST_LOAD: begin
                state_d  = ST_SETUP;
                tmr_load = 1'b1;
                tmr_val  = LD_SU;
            end
            ST_SETUP: begin
                if (tmr_done) begin
                    state_d  = ST_EN;
                    tmr_load = 1'b1;
                    tmr_val  = LD_EN;
                end
            end
            ST_EN: begin
                if (tmr_done) begin
                    state_d  = ST_HOLD;
                    tmr_load = 1'b1;
                    tmr_val  = LD_HOLD;
                end
            end
            ST_HOLD: begin
                if (tmr_done) begin
`ifdef LCD_BUSY_POLL_EN
                    if (use_poll) begin
                        state_d    = ST_POLL_SU;
                        tmr_load   = 1'b1;
                        tmr_val    = LD_SU;
                        poll_cnt_d = '0;
                    end else
`endif
                    begin
                        state_d  = ST_DELAY;
                        tmr_load = 1'b1;
                        tmr_val  = is_long_cmd(wr_q) ? LD_LONG : LD_CMD;
                    end
                end
            end
            ST_DELAY: begin
                if (tmr_done) begin
                    finish = 1'b1;
                end
            end
            ST_IDLE: begin
                if (in_valid && in_ready_q) begin
                    wr_d    = {in_rs, in_data};
                    state_d = ST_LOAD;
                end
            end
`ifdef LCD_BUSY_POLL_EN
            ST_POLL_SU: begin
                poll_cnt_d = poll_cnt_q + TW'(1);
                if (poll_timeout) begin
                    finish = 1'b1;
                end else if (tmr_done) begin
                    state_d  = ST_POLL_EN;
                    tmr_load = 1'b1;
                    tmr_val  = LD_EN;
                end
            end
            ST_POLL_EN: begin
                poll_cnt_d = poll_cnt_q + TW'(1);
                if (poll_timeout) begin
                    finish = 1'b1;
                end else if (tmr_done) begin
                    // Last enable-high cycle: the busy flag is valid on DB7
                    poll_busy_d = lcd_data_i[7];
                    state_d     = ST_POLL_HOLD;
                    tmr_load    = 1'b1;
                    tmr_val     = LD_HOLD;
                end
            end
            ST_POLL_HOLD: begin
                poll_cnt_d = poll_cnt_q + TW'(1);
                if (poll_timeout) begin
                    finish = 1'b1;
                end else if (tmr_done) begin
                    if (poll_busy_q) begin
                        state_d  = ST_POLL_SU;
                        tmr_load = 1'b1;
                        tmr_val  = LD_SU;
                    end else begin
                        finish = 1'b1;
                    end
                end
            end
`endif
            default: begin
                state_d = ST_PWRUP;
            end
        endcase

        if (finish) begin
            if (adv_init) begin
                state_d    = ST_LOAD;
                init_idx_d = init_idx_q + 3'd1;
                wr_d       = INIT_ROM[init_idx_q + 3'd1];
            end else begin
                state_d     = ST_IDLE;
                init_done_d = 1'b1;
            end
        end

        // Reset re-arms the power-up wait so PWRUP counts from the release
        if (!reset_reset_n) begin
            tmr_load = 1'b1;
            tmr_val  = LD_PWRUP;
        end
    end

    // Output decode from the next state so every pin is a plain flop
    always_comb begin
        lcd_en_d   = (state_d == ST_EN);
        lcd_rs_d   = lcd_rs_q;
        lcd_data_d = lcd_data_q;
        if (state_d == ST_LOAD) begin
            lcd_rs_d   = wr_d[8];
            lcd_data_d = wr_d[7:0];
        end
        in_ready_d = (state_d == ST_IDLE);
        busy_d     = (state_d != ST_IDLE);
`ifdef LCD_BUSY_POLL_EN
        poll_phase = (state_d == ST_POLL_SU) || (state_d == ST_POLL_EN) ||
                     (state_d == ST_POLL_HOLD);
        lcd_en_d   = (state_d == ST_EN) || (state_d == ST_POLL_EN);
        lcd_rw_d   = poll_phase;
        lcd_oe_d   = !poll_phase;
        if (poll_phase) begin
            lcd_rs_d = 1'b0;
        end
`endif
    end

    // Output registers; reset drops enable immediately and releases handshake
    always_ff @(posedge clk_clk) begin
        if (!reset_reset_n) begin
            lcd_en_q   <= 1'b0;
            lcd_rs_q   <= 1'b0;
            lcd_data_q <= 8'h00;
            in_ready_q <= 1'b0;
            busy_q     <= 1'b1;
`ifdef LCD_BUSY_POLL_EN
            lcd_rw_q   <= 1'b0;
            lcd_oe_q   <= 1'b1;
`endif
        end else begin
            lcd_en_q   <= lcd_en_d;
            lcd_rs_q   <= lcd_rs_d;
            lcd_data_q <= lcd_data_d;
            in_ready_q <= in_ready_d;
            busy_q     <= busy_d;
`ifdef LCD_BUSY_POLL_EN
            lcd_rw_q   <= lcd_rw_d;
            lcd_oe_q   <= lcd_oe_d;
`endif
        end
    end

    assign lcd_en     = lcd_en_q;
    assign lcd_rs     = lcd_rs_q;
    assign lcd_data_o = lcd_data_q;
    assign in_ready   = in_ready_q;
    assign busy       = busy_q;
    assign init_done  = init_done_q;
`ifdef LCD_BUSY_POLL_EN
    assign lcd_rw      = lcd_rw_q;
    assign lcd_data_oe = lcd_oe_q;
`else
    assign lcd_rw      = 1'b0;
    assign lcd_data_oe = 1'b1;
`endif

endmodule
